str_gbox_frac: RTL and testbench

- Stream gearbox between an up stream and a down stream of any two widths, including non-integer ratios (e.g. 3->8, 8->3, 10->16).
- Packs bits LSB-first into an internal bit-accumulator and emits full down words.
- On packet end (up_last), flushes the partial final word, zero-padded, and reports its valid bit count.
- Full valid/ready semantics on both sides: dn_val does not depend on dn_rdy, and there is no combinational path from dn_rdy to up_rdy. Used in front of and behind width-mismatched DMA/compute stream ports.

---
 rtl/str_gbox_frac.sv | 170 +++++++++++++++++
 tb/tb_str_gbox_frac.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/str_gbox_frac.sv
// str_gbox_frac: bit-accurate stream gearbox between arbitrary up/down widths.
// Up words are packed LSB-first into a bit accumulator. Full down words are
// emitted as soon as enough bits are held, and a packet end flushes the
// zero-padded tail word together with its valid bit count.
// Every output is a register loaded from the next-state values, so dn_val
// never depends on dn_rdy and up_rdy has no combinational path from dn_rdy.
module str_gbox_frac #(
    parameter  int DATA_UP_WIDTH = 3,
    parameter  int DATA_DN_WIDTH = 8,
    localparam int BUF_WIDTH     = DATA_UP_WIDTH + 2 * DATA_DN_WIDTH - 1,
    localparam int CNT_WIDTH     = $clog2(BUF_WIDTH + 1),
    localparam int BITS_WIDTH    = $clog2(DATA_DN_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_UP_WIDTH-1:0] up_data,
    input  logic                     up_last,
    input  logic                     up_val,
    output logic                     up_rdy,
    output logic [DATA_DN_WIDTH-1:0] dn_data,
    output logic                     dn_last,
    output logic [BITS_WIDTH-1:0]    dn_bits,
    output logic                     dn_val,
    input  logic                     dn_rdy
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_UP    = CNT_WIDTH'(DATA_UP_WIDTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_DN    = CNT_WIDTH'(DATA_DN_WIDTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_BUF   = CNT_WIDTH'(BUF_WIDTH);
    localparam logic [BITS_WIDTH-1:0] BITS_ZERO = {BITS_WIDTH{1'b0}};
    localparam logic [BITS_WIDTH-1:0] BITS_DN   = BITS_WIDTH'(DATA_DN_WIDTH);
    localparam logic [BUF_WIDTH-1:0]  BUF_ZERO  = {BUF_WIDTH{1'b0}};

    // Accumulator state
    logic [BUF_WIDTH-1:0]     buf_r;
    logic [CNT_WIDTH-1:0]     count_r;
    logic                     flush_r;

    // Registered outputs
    logic                     up_rdy_r;
    logic                     dn_val_r;
    logic                     dn_last_r;
    logic [BITS_WIDTH-1:0]    dn_bits_r;
    logic [DATA_DN_WIDTH-1:0] dn_data_r;

    // Next-state datapath
    logic                     up_fire_s;
    logic                     dn_fire_s;
    logic [CNT_WIDTH-1:0]     used_s;
    logic [CNT_WIDTH-1:0]     rem_s;
    logic [BUF_WIDTH-1:0]     shift_s;
    logic [BUF_WIDTH-1:0]     ins_s;
    logic [BUF_WIDTH-1:0]     buf_nxt_s;
    logic [CNT_WIDTH-1:0]     count_nxt_s;
    logic                     flush_nxt_s;
    logic [BITS_WIDTH-1:0]    dn_bits_nxt_s;

    // Room for one more up word, never while a packet end is draining.
    function automatic logic fits_f(input logic [CNT_WIDTH-1:0] cnt, input logic flush);
        return ~flush & (({1'b0, cnt} + {1'b0, CNT_UP}) <= {1'b0, CNT_BUF});
    endfunction

    // A full down word is held, or the drained tail still has bits.
    function automatic logic dn_val_f(input logic [CNT_WIDTH-1:0] cnt, input logic flush);
        return (cnt >= CNT_DN) | (flush & (cnt != CNT_ZERO));
    endfunction

    // The word on offer is the final one of the packet (may be full width).
    function automatic logic dn_last_f(input logic [CNT_WIDTH-1:0] cnt, input logic flush);
        return flush & (cnt <= CNT_DN) & (cnt != CNT_ZERO);
    endfunction

    // Valid bit count of the word on offer, zero when nothing is offered.
    function automatic logic [BITS_WIDTH-1:0] dn_bits_f(input logic [CNT_WIDTH-1:0] cnt,
                                                        input logic flush);
        logic [BITS_WIDTH-1:0] bits_v;
        if (!dn_val_f(cnt, flush)) begin
            bits_v = BITS_ZERO;
        end else if (dn_last_f(cnt, flush)) begin
            bits_v = cnt[BITS_WIDTH-1:0];
        end else begin
            bits_v = BITS_DN;
        end
        return bits_v;
    endfunction

    // Down word with every bit at or above the valid count forced to zero.
    function automatic logic [DATA_DN_WIDTH-1:0] dn_data_f(input logic [DATA_DN_WIDTH-1:0] low_v,
                                                           input logic [BITS_WIDTH-1:0] bits);
        logic [DATA_DN_WIDTH-1:0] mask_v;
        for (int i = 0; i < DATA_DN_WIDTH; i++) begin
            mask_v[i] = (BITS_WIDTH'(i) < bits);
        end
        return low_v & mask_v;
    endfunction

    // Keep only the accumulator bits below the valid count.
    function automatic logic [BUF_WIDTH-1:0] keep_low_f(input logic [BUF_WIDTH-1:0] acc_v,
                                                        input logic [CNT_WIDTH-1:0] cnt);
        logic [BUF_WIDTH-1:0] mask_v;
        for (int i = 0; i < BUF_WIDTH; i++) begin
            mask_v[i] = (CNT_WIDTH'(i) < cnt);
        end
        return acc_v & mask_v;
    endfunction

    // Handshakes, bits consumed this cycle and the next accumulator contents.
    always_comb begin
        up_fire_s = up_val & up_rdy_r;
        dn_fire_s = dn_val_r & dn_rdy;
        if (dn_fire_s) begin
            if (count_r < CNT_DN) begin
                used_s = count_r;
            end else begin
                used_s = CNT_DN;
            end
        end else begin
            used_s = CNT_ZERO;
        end
        rem_s   = count_r - used_s;
        shift_s = buf_r >> used_s;
        if (up_fire_s) begin
            ins_s       = BUF_WIDTH'(up_data) << rem_s;
            count_nxt_s = rem_s + CNT_UP;
        end else begin
            ins_s       = BUF_ZERO;
            count_nxt_s = rem_s;
        end
        buf_nxt_s = keep_low_f(shift_s | ins_s, count_nxt_s);
        if (up_fire_s & up_last) begin
            flush_nxt_s = 1'b1;
        end else if (dn_fire_s & dn_last_r) begin
            flush_nxt_s = 1'b0;
        end else begin
            flush_nxt_s = flush_r;
        end
        dn_bits_nxt_s = dn_bits_f(count_nxt_s, flush_nxt_s);
    end

    // State and output registers; reset drops every buffered bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r     <= BUF_ZERO;
            count_r   <= CNT_ZERO;
            flush_r   <= 1'b0;
            up_rdy_r  <= 1'b0;
            dn_val_r  <= 1'b0;
            dn_last_r <= 1'b0;
            dn_bits_r <= BITS_ZERO;
            dn_data_r <= {DATA_DN_WIDTH{1'b0}};
        end else begin
            buf_r     <= buf_nxt_s;
            count_r   <= count_nxt_s;
            flush_r   <= flush_nxt_s;
            up_rdy_r  <= fits_f(count_nxt_s, flush_nxt_s);
            dn_val_r  <= dn_val_f(count_nxt_s, flush_nxt_s);
            dn_last_r <= dn_last_f(count_nxt_s, flush_nxt_s);
            dn_bits_r <= dn_bits_nxt_s;
            dn_data_r <= dn_data_f(buf_nxt_s[DATA_DN_WIDTH-1:0], dn_bits_nxt_s);
        end
    end

    assign up_rdy  = up_rdy_r;
    assign dn_val  = dn_val_r;
    assign dn_last = dn_last_r;
    assign dn_bits = dn_bits_r;
    assign dn_data = dn_data_r;

endmodule

// File: tb/tb_str_gbox_frac.sv
// tb_str_gbox_frac: directed checks on fixed geometries plus randomized
// bitstream scoreboards over a grid of up/down widths.
module tb_str_gbox_frac;

    int total = 0;
    int bad   = 0;
    int rand_done = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_rand_n;

    // Clock generator
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- directed instances ----------------
    logic [2:0] a_ud; logic a_ul, a_uv, a_ur; logic [7:0] a_dd; logic a_dl, a_dv, a_dr; logic [3:0] a_db;
    logic [7:0] b_ud; logic b_ul, b_uv, b_ur; logic [2:0] b_dd; logic b_dl, b_dv, b_dr; logic [1:0] b_db;
    logic [7:0] c_ud; logic c_ul, c_uv, c_ur; logic [7:0] c_dd; logic c_dl, c_dv, c_dr; logic [3:0] c_db;
    logic [3:0] d_ud; logic d_ul, d_uv, d_ur; logic [7:0] d_dd; logic d_dl, d_dv, d_dr; logic [3:0] d_db;

    str_gbox_frac #(.DATA_UP_WIDTH(3), .DATA_DN_WIDTH(8)) u38 (
        .clk(clk), .rst_n(rst_n), .up_data(a_ud), .up_last(a_ul), .up_val(a_uv), .up_rdy(a_ur),
        .dn_data(a_dd), .dn_last(a_dl), .dn_bits(a_db), .dn_val(a_dv), .dn_rdy(a_dr));
    str_gbox_frac #(.DATA_UP_WIDTH(8), .DATA_DN_WIDTH(3)) u83 (
        .clk(clk), .rst_n(rst_n), .up_data(b_ud), .up_last(b_ul), .up_val(b_uv), .up_rdy(b_ur),
        .dn_data(b_dd), .dn_last(b_dl), .dn_bits(b_db), .dn_val(b_dv), .dn_rdy(b_dr));
    str_gbox_frac #(.DATA_UP_WIDTH(8), .DATA_DN_WIDTH(8)) u88 (
        .clk(clk), .rst_n(rst_n), .up_data(c_ud), .up_last(c_ul), .up_val(c_uv), .up_rdy(c_ur),
        .dn_data(c_dd), .dn_last(c_dl), .dn_bits(c_db), .dn_val(c_dv), .dn_rdy(c_dr));
    str_gbox_frac #(.DATA_UP_WIDTH(4), .DATA_DN_WIDTH(8)) u48 (
        .clk(clk), .rst_n(rst_n), .up_data(d_ud), .up_last(d_ul), .up_val(d_uv), .up_rdy(d_ur),
        .dn_data(d_dd), .dn_last(d_dl), .dn_bits(d_db), .dn_val(d_dv), .dn_rdy(d_dr));

    // ---------------- randomized width grid ----------------
    localparam int UPW [0:4] = '{1, 3, 5, 8, 13};
    localparam int DNW [0:3] = '{1, 4, 7, 16};

    for (genvar gi = 0; gi < 5; gi++) begin : g_up
        for (genvar gj = 0; gj < 4; gj++) begin : g_dn
            localparam int UW  = UPW[gi];
            localparam int DW  = DNW[gj];
            localparam int BW  = UW + 2 * DW - 1;
            localparam int BTW = $clog2(DW + 1);
            logic [UW-1:0] ud; logic ul, uv, ur;
            logic [DW-1:0] dd; logic dl, dv, dr; logic [BTW-1:0] db;

            str_gbox_frac #(.DATA_UP_WIDTH(UW), .DATA_DN_WIDTH(DW)) dut (
                .clk(clk), .rst_n(rst_rand_n), .up_data(ud), .up_last(ul), .up_val(uv),
                .up_rdy(ur), .dn_data(dd), .dn_last(dl), .dn_bits(db), .dn_val(dv), .dn_rdy(dr));

            // Random packets: expected down words are cut from the packet's bit list.
            initial begin : rnd
                bit            sb[$];
                logic [UW-1:0] words[$];
                bit            lasts[$];
                logic [31:0]   ed[$];
                int            eb[$];
                bit            el[$];
                logic [UW-1:0] v;
                logic [31:0]   w32;
                int            nw, n, idx, cyc;
                bit            fired;
                ud = '0; ul = 1'b0; uv = 1'b0; dr = 1'b0;
                for (int p = 0; p < 6; p++) begin
                    nw = $urandom_range(1, 10);
                    for (int w = 0; w < nw; w++) begin
                        v = UW'($urandom);
                        words.push_back(v);
                        lasts.push_back(w == nw - 1);
                        for (int b = 0; b < UW; b++) sb.push_back(v[b]);
                    end
                    while (sb.size() > 0) begin
                        n   = (sb.size() < DW) ? sb.size() : DW;
                        w32 = 32'd0;
                        for (int b = 0; b < n; b++) w32[b] = sb.pop_front();
                        ed.push_back(w32);
                        eb.push_back(n);
                        el.push_back(sb.size() == 0);
                    end
                end
                wait (rst_rand_n === 1'b1);
                idx = 0; cyc = 0; fired = 1'b0;
                while ((idx < words.size() || ed.size() > 0) && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    chk("rnd_cnt_bound", 32'(32'(dut.count_r) <= BW), 32'd1);
                    dr = ($urandom_range(0, 3) != 0);
                    if (dv && dr) begin
                        if (ed.size() == 0) begin
                            chk("rnd_extra_word", 32'd1, 32'd0);
                        end else begin
                            chk("rnd_data", 32'(dd), ed[0]);
                            chk("rnd_bits", 32'(db), 32'(eb[0]));
                            chk("rnd_last", 32'(dl), 32'(el[0]));
                            void'(ed.pop_front());
                            void'(eb.pop_front());
                            void'(el.pop_front());
                        end
                    end
                    if (idx < words.size()) begin
                        if (!uv || fired) uv = ($urandom_range(0, 3) != 0);
                        fired = 1'b0;
                        ud = words[idx];
                        ul = lasts[idx];
                        if (uv && ur) begin
                            idx++;
                            fired = 1'b1;
                        end
                    end else begin
                        uv = 1'b0; ul = 1'b0; fired = 1'b0;
                    end
                end
                chk("rnd_complete", 32'((ed.size() == 0) && (idx == words.size())), 32'd1);
                rand_done++;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [31:0] s4, s5;
        logic [2:0]  v3;
        int          nw, cyc;
        bit          sent7;
        rst_n = 1'b0; rst_rand_n = 1'b0;
        a_ud = 3'd0; a_ul = 1'b0; a_uv = 1'b0; a_dr = 1'b1;
        b_ud = 8'd0; b_ul = 1'b0; b_uv = 1'b0; b_dr = 1'b1;
        c_ud = 8'd0; c_ul = 1'b0; c_uv = 1'b0; c_dr = 1'b1;
        d_ud = 4'd0; d_ul = 1'b0; d_uv = 1'b0; d_dr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dn_val",  32'(a_dv), 32'd0);
        chk("rst_dn_last", 32'(a_dl), 32'd0);
        chk("rst_dn_bits", 32'(a_db), 32'd0);
        chk("rst_dn_data", 32'(a_dd), 32'd0);
        chk("rst_up_rdy",  32'(a_ur), 32'd0);
        rst_n = 1'b1; rst_rand_n = 1'b1;
        @(negedge clk);
        chk("post_rst_up_rdy", 32'(a_ur), 32'd1);
        chk("post_rst_dn_val", 32'(a_dv), 32'd0);

        // 3 -> 8: 101, 011, 110(last) gives 0x9D then 0x01 (1 bit, last)
        a_uv = 1'b1; a_ud = 3'b101; a_ul = 1'b0;
        @(negedge clk);
        chk("t1_val_3b", 32'(a_dv), 32'd0);
        a_ud = 3'b011;
        @(negedge clk);
        chk("t1_val_6b", 32'(a_dv), 32'd0);
        a_ud = 3'b110; a_ul = 1'b1;
        @(negedge clk);
        a_uv = 1'b0; a_ul = 1'b0;
        chk("t1_w0_val",  32'(a_dv), 32'd1);
        chk("t1_w0_data", 32'(a_dd), 32'h9D);
        chk("t1_w0_last", 32'(a_dl), 32'd0);
        chk("t1_w0_bits", 32'(a_db), 32'd8);
        chk("t1_rdy_flush", 32'(a_ur), 32'd0);
        @(negedge clk);
        chk("t1_w1_val",  32'(a_dv), 32'd1);
        chk("t1_w1_data", 32'(a_dd), 32'h01);
        chk("t1_w1_last", 32'(a_dl), 32'd1);
        chk("t1_w1_bits", 32'(a_db), 32'd1);
        @(negedge clk);
        chk("t1_idle_val", 32'(a_dv), 32'd0);
        chk("t1_idle_rdy", 32'(a_ur), 32'd1);

        // 8 -> 3: 0xA5(last) gives 5, 4, then 2 with 2 valid bits
        chk("t2_rdy0", 32'(b_ur), 32'd1);
        b_uv = 1'b1; b_ud = 8'hA5; b_ul = 1'b1;
        @(negedge clk);
        b_uv = 1'b0; b_ul = 1'b0;
        chk("t2_w0_data", 32'(b_dd), 32'd5);
        chk("t2_w0_last", 32'(b_dl), 32'd0);
        chk("t2_w0_bits", 32'(b_db), 32'd3);
        chk("t2_w0_rdy",  32'(b_ur), 32'd0);
        @(negedge clk);
        chk("t2_w1_data", 32'(b_dd), 32'd4);
        chk("t2_w1_rdy",  32'(b_ur), 32'd0);
        @(negedge clk);
        chk("t2_w2_val",  32'(b_dv), 32'd1);
        chk("t2_w2_data", 32'(b_dd), 32'd2);
        chk("t2_w2_last", 32'(b_dl), 32'd1);
        chk("t2_w2_bits", 32'(b_db), 32'd2);
        chk("t2_w2_rdy",  32'(b_ur), 32'd0);
        @(negedge clk);
        chk("t2_idle_val", 32'(b_dv), 32'd0);
        chk("t2_idle_rdy", 32'(b_ur), 32'd1);

        // 8 -> 8: 16 counting words stream through at full rate
        chk("t3_rdy0", 32'(c_ur), 32'd1);
        c_uv = 1'b1; c_ud = 8'd1; c_ul = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k <= 16) begin
                chk("t3_val",  32'(c_dv), 32'd1);
                chk("t3_data", 32'(c_dd), 32'(k));
                chk("t3_last", 32'(c_dl), 32'(k == 16));
                chk("t3_bits", 32'(c_db), 32'd8);
            end else begin
                chk("t3_idle_val", 32'(c_dv), 32'd0);
            end
            if (k < 16) begin
                chk("t3_rdy", 32'(c_ur), 32'd1);
                c_ud = 8'(k + 1);
                c_ul = (k == 15);
            end else begin
                c_uv = 1'b0; c_ul = 1'b0;
            end
        end

        // 3 -> 8 with downstream stalled: fill to 18 bits, hold, then drain
        a_dr = 1'b0; s4 = 32'd0;
        for (int w = 0; w < 6; w++) begin
            chk("t4_rdy_fill", 32'(a_ur), 32'd1);
            v3 = 3'($urandom);
            a_uv = 1'b1; a_ud = v3; a_ul = 1'b0;
            s4 = s4 | (32'(v3) << (3 * w));
            @(negedge clk);
        end
        v3 = 3'($urandom);
        a_ud = v3; a_ul = 1'b1;
        s4 = s4 | (32'(v3) << 18);
        for (int h = 0; h < 5; h++) begin
            chk("t4_full_rdy",  32'(a_ur), 32'd0);
            chk("t4_hold_val",  32'(a_dv), 32'd1);
            chk("t4_hold_data", 32'(a_dd), s4 & 32'hFF);
            chk("t4_hold_bits", 32'(a_db), 32'd8);
            chk("t4_hold_last", 32'(a_dl), 32'd0);
            @(negedge clk);
        end
        a_dr = 1'b1; nw = 0; cyc = 0; sent7 = 1'b0;
        while (nw < 3 && cyc < 50) begin
            if (a_uv && a_ur) sent7 = 1'b1;
            if (a_dv) begin
                chk("t4_data", 32'(a_dd), (s4 >> (8 * nw)) & 32'hFF);
                chk("t4_bits", 32'(a_db), (nw < 2) ? 32'd8 : 32'd5);
                chk("t4_last", 32'(a_dl), 32'(nw == 2));
                nw++;
            end
            @(negedge clk);
            cyc++;
            if (sent7) begin
                a_uv = 1'b0; a_ul = 1'b0;
            end
        end
        chk("t4_words", 32'(nw), 32'd3);
        chk("t4_idle_val", 32'(a_dv), 32'd0);

        // 4 -> 8: a 16-bit packet gives exactly two words, the second full and last
        s5 = 32'($urandom_range(0, 65535));
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            if (d_dv) begin
                if (nw < 2) begin
                    chk("t5_data", 32'(d_dd), (s5 >> (8 * nw)) & 32'hFF);
                    chk("t5_bits", 32'(d_db), 32'd8);
                    chk("t5_last", 32'(d_dl), 32'(nw == 1));
                end else begin
                    chk("t5_extra_word", 32'd1, 32'd0);
                end
                nw++;
            end
            if (i < 4) begin
                d_uv = 1'b1;
                d_ud = 4'(s5 >> (4 * i));
                d_ul = (i == 3);
            end else begin
                d_uv = 1'b0; d_ul = 1'b0;
            end
            @(negedge clk);
        end
        chk("t5_words", 32'(nw), 32'd2);

        // Reset while a flushed tail is waiting, then a fresh packet
        a_dr = 1'b0;
        for (int w = 0; w < 3; w++) begin
            a_uv = 1'b1; a_ud = 3'b111; a_ul = (w == 2);
            @(negedge clk);
        end
        a_uv = 1'b0; a_ul = 1'b0;
        chk("t6_pre_val", 32'(a_dv), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_val",  32'(a_dv), 32'd0);
        chk("t6_async_last", 32'(a_dl), 32'd0);
        chk("t6_async_bits", 32'(a_db), 32'd0);
        chk("t6_async_rdy",  32'(a_ur), 32'd0);
        chk("t6_async_cnt",  32'(u38.count_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; a_dr = 1'b1;
        @(negedge clk);
        chk("t6_rel_rdy", 32'(a_ur), 32'd1);
        chk("t6_rel_val", 32'(a_dv), 32'd0);
        a_uv = 1'b1; a_ud = 3'b111; a_ul = 1'b1;
        @(negedge clk);
        a_uv = 1'b0; a_ul = 1'b0;
        chk("t6_new_val",  32'(a_dv), 32'd1);
        chk("t6_new_data", 32'(a_dd), 32'h07);
        chk("t6_new_bits", 32'(a_db), 32'd3);
        chk("t6_new_last", 32'(a_dl), 32'd1);
        @(negedge clk);
        chk("t6_end_val", 32'(a_dv), 32'd0);

        cyc = 0;
        while (rand_done < 20 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rand_all_done", 32'(rand_done), 32'd20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
